l2c_read_ctrl: RTL and testbench

Parametrised L2 cache read-path controller between the MNI read port and the L2 tag/SRAM pipeline.
- Latches the request address at accept.
- Issues a tag lookup and handles hit/miss/retry.
- Bounds retries with a programmable limit that forces a NACK.
- Sequences a multi-beat SRAM line read with a per-beat address offset.
- Sits beside the L2C write and maintenance controllers and shares the tag arbiter and broadcast lines with them.

---
 rtl/l2c_read_ctrl.sv | 142 ++++++++++++++
 tb/tb_l2c_read_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2c_read_ctrl.sv
// L2 cache read-path controller: accepts an MNI read, runs the tag lookup with
// bounded retries, then streams the line out of the SRAM beat by beat.
module l2c_read_ctrl #(
    parameter int SET_BITS   = 9,
    parameter int WAY_BITS   = 3,
    parameter int LINE_BITS  = 6,
    parameter int BEAT_BYTES = 16,
    parameter int RETRY_MAX  = 15,
    parameter int RETRY_W    = 4
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  i_maintenance_active,
    input  logic [31:0]                           i_mni_read_adr,
    input  logic                                  i_mni_read_valid,
    input  logic                                  i_hit,
    input  logic                                  i_miss,
    input  logic                                  i_retry,
    input  logic [WAY_BITS-1:0]                   i_way,
    input  logic                                  i_wb_ack_broadcast,
    input  logic                                  i_fill_broadcast,
    input  logic                                  i_write_broadcast,
    input  logic                                  i_start,
    input  logic                                  i_beat,
    output logic                                  o_read_idle,
    output logic                                  o_tag_req,
    output logic [SET_BITS+WAY_BITS+LINE_BITS-1:0] o_sram_adr,
    output logic                                  o_mni_read_stall,
    output logic                                  o_mni_read_nack,
    output logic                                  o_mni_data_valid,
    output logic                                  o_retry_timeout
);
    localparam int BEATS  = (1 << LINE_BITS) / BEAT_BYTES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_SH = $clog2(BEAT_BYTES);

    localparam int S_IDLE   = 0;
    localparam int S_TAGS   = 1;
    localparam int S_RETRY  = 2;
    localparam int S_SRAM   = 3;
    localparam int S_ACCESS = 4;
    localparam int S_UNLOCK = 5;
    localparam int S_NACK   = 6;

    localparam logic [6:0] ST_IDLE   = 7'b0000001;
    localparam logic [6:0] ST_TAGS   = 7'b0000010;
    localparam logic [6:0] ST_RETRY  = 7'b0000100;
    localparam logic [6:0] ST_SRAM   = 7'b0001000;
    localparam logic [6:0] ST_ACCESS = 7'b0010000;
    localparam logic [6:0] ST_UNLOCK = 7'b0100000;
    localparam logic [6:0] ST_NACK   = 7'b1000000;

    logic [6:0]          state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                timeout_q, timeout_d;

    logic accept;
    logic any_bcast;
    logic retry_at_max;
    logic last_beat;
    logic [LINE_BITS-1:0] beat_off;
    logic unused_adr;

    assign accept       = i_mni_read_valid & ~i_maintenance_active;
    assign any_bcast    = i_wb_ack_broadcast | i_fill_broadcast | i_write_broadcast;
    assign retry_at_max = (retry_cnt_q == RETRY_W'(RETRY_MAX));
    assign last_beat    = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign unused_adr   = ^i_mni_read_adr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            set_q       <= '0;
            way_q       <= '0;
            retry_cnt_q <= '0;
            beat_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            way_q       <= way_d;
            retry_cnt_q <= retry_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Tag responses are prioritised hit > miss > retry.
    always_comb begin
        state_d = state_q;
        case (1'b1)
            state_q[S_IDLE]:   if (accept) state_d = ST_TAGS;
            state_q[S_TAGS]: begin
                if (i_hit)         state_d = ST_SRAM;
                else if (i_miss)   state_d = ST_NACK;
                else if (i_retry)  state_d = retry_at_max ? ST_NACK : ST_RETRY;
            end
            state_q[S_RETRY]:  if (any_bcast) state_d = ST_TAGS;
            state_q[S_SRAM]:   if (i_start) state_d = ST_ACCESS;
            state_q[S_ACCESS]: if (i_beat && last_beat) state_d = ST_UNLOCK;
            state_q[S_UNLOCK]: state_d = ST_IDLE;
            state_q[S_NACK]:   state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        set_d       = set_q;
        way_d       = way_q;
        retry_cnt_d = retry_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        timeout_d   = 1'b0;
        if (state_q[S_IDLE] && accept) begin
            set_d       = i_mni_read_adr[LINE_BITS+SET_BITS-1:LINE_BITS];
            retry_cnt_d = '0;
        end
        if (state_q[S_TAGS]) begin
            if (i_hit) begin
                way_d = i_way;
            end else if (!i_miss && i_retry) begin
                if (retry_at_max) timeout_d = 1'b1;
                else              retry_cnt_d = retry_cnt_q + 1'b1;
            end
        end
        if (state_q[S_SRAM] && i_start) beat_cnt_d = '0;
        if (state_q[S_ACCESS] && i_beat) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end

    always_comb begin
        beat_off         = state_q[S_ACCESS] ? (LINE_BITS'(beat_cnt_q) << OFF_SH) : '0;
        o_read_idle      = state_q[S_IDLE];
        o_tag_req        = state_q[S_TAGS];
        o_sram_adr       = {set_q, way_q, beat_off};
        o_mni_read_stall = ~(state_q[S_NACK] | state_q[S_UNLOCK]);
        o_mni_read_nack  = state_q[S_NACK];
        o_mni_data_valid = state_q[S_ACCESS] & i_beat;
        o_retry_timeout  = timeout_q;
    end
endmodule

// File: tb/tb_l2c_read_ctrl.sv
// Randomised scoreboard bench for l2c_read_ctrl: the driver pushes expected
// MNI-side events, a negedge monitor pops and compares them.
module tb_l2c_read_ctrl;
    localparam int SET_BITS   = 9;
    localparam int WAY_BITS   = 3;
    localparam int LINE_BITS  = 6;
    localparam int BEAT_BYTES = 16;
    localparam int RETRY_MAX  = 2;
    localparam int RETRY_W    = 4;
    localparam int BEATS      = (1 << LINE_BITS) / BEAT_BYTES;
    localparam int ADR_W      = SET_BITS + WAY_BITS + LINE_BITS;

    logic             Clk, Reset;
    logic             i_maintenance_active, i_mni_read_valid;
    logic [31:0]      i_mni_read_adr;
    logic             i_hit, i_miss, i_retry;
    logic [WAY_BITS-1:0] i_way;
    logic             i_wb_ack_broadcast, i_fill_broadcast, i_write_broadcast;
    logic             i_start, i_beat;
    logic             o_read_idle, o_tag_req, o_mni_read_stall, o_mni_read_nack;
    logic             o_mni_data_valid, o_retry_timeout;
    logic [ADR_W-1:0] o_sram_adr;

    l2c_read_ctrl #(
        .SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS), .LINE_BITS(LINE_BITS),
        .BEAT_BYTES(BEAT_BYTES), .RETRY_MAX(RETRY_MAX), .RETRY_W(RETRY_W)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .i_maintenance_active(i_maintenance_active),
        .i_mni_read_adr(i_mni_read_adr), .i_mni_read_valid(i_mni_read_valid),
        .i_hit(i_hit), .i_miss(i_miss), .i_retry(i_retry), .i_way(i_way),
        .i_wb_ack_broadcast(i_wb_ack_broadcast), .i_fill_broadcast(i_fill_broadcast),
        .i_write_broadcast(i_write_broadcast),
        .i_start(i_start), .i_beat(i_beat),
        .o_read_idle(o_read_idle), .o_tag_req(o_tag_req), .o_sram_adr(o_sram_adr),
        .o_mni_read_stall(o_mni_read_stall), .o_mni_read_nack(o_mni_read_nack),
        .o_mni_data_valid(o_mni_data_valid), .o_retry_timeout(o_retry_timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // kind: 0 = data beat, 1 = nack, 2 = completion (stall released)
    typedef struct {
        int kind;
        int adr;
        int tmo;
        int tags;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  tag_eps = 0;
    logic tag_prev = 1'b0;
    int  txn_id  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_ev(input int kind, input int adr, input int tmo, input int tags);
        ev_t e;
        e.kind = kind; e.adr = adr; e.tmo = tmo; e.tags = tags;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input int kind, input int adr, input int tmo);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: kind %0d adr 0x%0h with nothing expected", kind, adr);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == 0) chk("beat_sram_adr", adr, e.adr);
            if (e.kind == 1) begin
                chk("nack_timeout_flag", tmo, e.tmo);
                chk("nack_tag_episodes", tag_eps, e.tags);
            end
            if (e.kind == 2) chk("done_tag_episodes", tag_eps, e.tags);
        end
        if (kind != 0) tag_eps = 0;
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            tag_eps  = 0;
            tag_prev = 1'b0;
        end else begin
            if (o_tag_req && !tag_prev) tag_eps++;
            tag_prev = o_tag_req;
            if (o_mni_data_valid) mon_event(0, int'(o_sram_adr), 0);
            if (o_mni_read_nack) mon_event(1, 0, int'(o_retry_timeout));
            else if (!o_mni_read_stall) mon_event(2, 0, 0);
            if (o_retry_timeout && !o_mni_read_nack) mon_event(3, 0, 1);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic bcast_pulse();
        int w;
        w = $urandom_range(0, 2);
        i_wb_ack_broadcast = (w == 0);
        i_fill_broadcast   = (w == 1);
        i_write_broadcast  = (w == 2);
    endtask

    task automatic bcast_clear();
        i_wb_ack_broadcast = 1'b0;
        i_fill_broadcast   = 1'b0;
        i_write_broadcast  = 1'b0;
    endtask

    // kind: 0 = hit, 1 = miss, 2 = retry exhaustion. gap < 0 means random beat spacing.
    task automatic do_req(input int adr, input int kind, input int nretry, input int way,
                          input int maint, input int gap, input bit reset_mid);
        int set_f, ntries, base, g;
        set_f  = (adr >> LINE_BITS) & ((1 << SET_BITS) - 1);
        ntries = (kind == 2) ? RETRY_MAX + 1 : nretry;
        txn_id++;
        $display("txn %0d: adr=0x%08h kind=%0d retries=%0d way=%0d maint=%0d reset_mid=%0d",
                 txn_id, adr, kind, ntries, way, maint, reset_mid);
        chk("idle_before_req", o_read_idle, 1);
        i_mni_read_adr       = adr;
        i_mni_read_valid     = 1'b1;
        i_maintenance_active = (maint > 0);
        for (int m = 0; m < maint; m++) begin
            step();
            chk("maint_holds_idle", o_read_idle, 1);
            chk("maint_no_tag_req", o_tag_req, 0);
        end
        i_maintenance_active = 1'b0;
        step();
        chk("accept_to_tag_req", o_tag_req, 1);
        i_mni_read_adr = $urandom;
        for (int r = 0; r < ntries; r++) begin
            g = $urandom_range(0, 2);
            for (int w = 0; w < g; w++) begin
                if ($urandom_range(0, 1) == 1) bcast_pulse();
                step();
                bcast_clear();
                chk("tags_hold_without_resp", o_tag_req, 1);
            end
            i_retry = 1'b1;
            if (kind == 2 && r == ntries - 1) push_ev(1, 0, 1, ntries);
            step();
            i_retry = 1'b0;
            if (kind == 2 && r == ntries - 1) begin
                chk("timeout_nack", o_mni_read_nack, 1);
                chk("timeout_pulse", o_retry_timeout, 1);
                i_mni_read_valid = 1'b0;
                step();
                chk("nack_one_cycle", o_mni_read_nack, 0);
                chk("timeout_one_cycle", o_retry_timeout, 0);
                chk("idle_after_nack", o_read_idle, 1);
                return;
            end
            chk("retry_leaves_tags", o_tag_req, 0);
            g = $urandom_range(0, 3);
            for (int w = 0; w < g; w++) begin
                step();
                chk("retry_waits_bcast", o_tag_req, 0);
            end
            bcast_pulse();
            step();
            bcast_clear();
            chk("bcast_to_tag_req", o_tag_req, 1);
        end
        if (kind == 1) begin
            i_miss = 1'b1;
            push_ev(1, 0, 0, ntries + 1);
            step();
            i_miss = 1'b0;
            chk("miss_to_nack", o_mni_read_nack, 1);
            chk("miss_no_timeout", o_retry_timeout, 0);
            i_mni_read_valid = 1'b0;
            step();
            chk("nack_one_cycle", o_mni_read_nack, 0);
            chk("idle_after_nack", o_read_idle, 1);
            return;
        end
        i_hit   = 1'b1;
        i_way   = way[WAY_BITS-1:0];
        i_miss  = 1'($urandom_range(0, 1));
        i_retry = 1'($urandom_range(0, 1));
        step();
        i_hit = 1'b0; i_miss = 1'b0; i_retry = 1'b0; i_way = '0;
        chk("hit_to_sram_no_tag", o_tag_req, 0);
        chk("hit_to_sram_stall", o_mni_read_stall, 1);
        g = $urandom_range(0, 2);
        for (int w = 0; w < g; w++) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        base = (set_f << (WAY_BITS + LINE_BITS)) | (way << LINE_BITS);
        for (int k = 0; k < BEATS; k++) begin
            if (reset_mid && k == 2) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                exp_q.delete();
                chk("reset_mid_idle", o_read_idle, 1);
                chk("reset_mid_sram_adr", o_sram_adr, 0);
                chk("reset_mid_stall", o_mni_read_stall, 1);
                i_mni_read_valid = 1'b0;
                return;
            end
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            for (int w = 0; w < g; w++) step();
            i_beat = 1'b1;
            push_ev(0, base + k * BEAT_BYTES, 0, 0);
            if (k == BEATS - 1) push_ev(2, 0, 0, ntries + 1);
            step();
            i_beat = 1'b0;
        end
        chk("last_beat_releases_stall", o_mni_read_stall, 0);
        i_mni_read_valid = 1'b0;
        step();
        chk("idle_after_unlock", o_read_idle, 1);
        chk("stall_after_unlock", o_mni_read_stall, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, nr, adr;
        Reset = 1'b1;
        i_maintenance_active = 1'b0; i_mni_read_valid = 1'b0; i_mni_read_adr = '0;
        i_hit = 1'b0; i_miss = 1'b0; i_retry = 1'b0; i_way = '0;
        bcast_clear();
        i_start = 1'b0; i_beat = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        step();
        chk("reset_idle", o_read_idle, 1);
        chk("reset_stall", o_mni_read_stall, 1);
        chk("reset_sram_adr", o_sram_adr, 0);
        chk("reset_tag_req", o_tag_req, 0);
        chk("reset_nack", o_mni_read_nack, 0);
        chk("reset_data_valid", o_mni_data_valid, 0);
        chk("reset_timeout", o_retry_timeout, 0);

        do_req(32'h0000_1A40, 0, 0, 5, 0, 1, 1'b0);
        do_req(int'($urandom), 1, 0, 0, 0, -1, 1'b0);
        do_req(int'($urandom), 0, 1, 3, 0, -1, 1'b0);
        do_req(int'($urandom), 2, 0, 0, 0, -1, 1'b0);
        do_req(int'($urandom), 0, 0, 6, 5, -1, 1'b0);
        do_req(int'($urandom), 0, 0, 2, 0, 0, 1'b1);
        step();
        do_req(32'h0000_0040, 0, 0, 7, 0, 0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) kind = 0;
            nr  = $urandom_range(0, RETRY_MAX);
            adr = int'($urandom);
            do_req(adr, kind, nr, $urandom_range(0, 7), $urandom_range(0, 2), -1,
                   (kind == 0) && ($urandom_range(0, 19) == 0));
            for (int w = int'($urandom_range(0, 2)); w > 0; w--) begin
                step();
                chk("idle_between_reqs", o_read_idle, 1);
            end
        end
        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
